bch_wrapper_encoder_mem: RTL and testbench



---
 rtl/bch_wrapper_encoder_mem_pkg.sv | 20 ++
 rtl/bch_wrapper_encoder_mem_lfsr.sv | 40 ++++
 rtl/bch_wrapper_encoder_mem.sv | 172 +++++++++++++++++
 tb/tb_bch_wrapper_encoder_mem.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_wrapper_encoder_mem_pkg.sv
// Shared definitions for the BCH helper-data encoder/decoder wrapper pair:
// the sequencer state encoding and the memory word-count rule that both
// sides must agree on for the helper-data layout.
package bch_wrapper_encoder_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } bch_state_t;

  // Number of memory words holding E parity bits in W-bit words. When E is
  // an exact multiple of W this still yields one extra all-zero word, which
  // matches the decoder's read-back loop.
  function automatic int mem_cycle(input int ecc_bits, input int word_bits);
    return ecc_bits / word_bits + 1;
  endfunction

endpackage

// File: rtl/bch_wrapper_encoder_mem_lfsr.sv
// Serial BCH parity LFSR: divides the message (MSB first) times x^E by the
// generator polynomial, leaving the systematic parity in the register.
module bch_lfsr_parity #(
  parameter int                    C_ECC_BITS = 3,
  parameter logic [C_ECC_BITS-1:0] C_GEN_POLY = 3'b011
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_clear,
  input  logic                  I_shift,
  input  logic                  I_bit,
  output logic [C_ECC_BITS-1:0] O_par,
  output logic [C_ECC_BITS-1:0] O_par_next
);

  logic [C_ECC_BITS-1:0] par_q;
  logic [C_ECC_BITS-1:0] par_d;
  logic                  fb;

  // Next parity: clear has priority, otherwise one division step per shift.
  always_comb begin
    par_d = par_q;
    fb    = I_bit ^ par_q[C_ECC_BITS-1];
    if (I_clear) begin
      par_d = '0;
    end else if (I_shift) begin
      par_d = (par_q << 1) ^ (fb ? C_GEN_POLY : '0);
    end
  end

  // Parity register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) par_q <= '0;
    else          par_q <= par_d;
  end

  assign O_par      = par_q;
  assign O_par_next = par_d;

endmodule

// File: rtl/bch_wrapper_encoder_mem.sv
// Enrollment-side BCH encoder: computes parity for one PUF response word
// with a serial LFSR, writes it into helper-data memory in the layout the
// decoder wrapper reads back, then pulses done.
module bch_wrapper_encoder_mem
  import bch_wrapper_encoder_mem_pkg::*;
#(
  parameter int                         C_I_DATABITS    = 4,
  parameter int                         C_ECC_BITS      = 3,
  parameter logic [C_ECC_BITS-1:0]      C_GEN_POLY      = 3'b011,
  parameter int                         C_MEM_ADDR_SIZE = 10,
  parameter int                         C_MEM_DATA_SIZE = 8,
  parameter logic [C_MEM_ADDR_SIZE-1:0] C_MEM_ST_ADDR   = '0
) (
  input  logic                       I_clk,
  input  logic                       I_rst_n,
  input  logic                       I_en,
  input  logic                       I_start,
  input  logic [C_I_DATABITS-1:0]    I_data,
  output logic [C_MEM_ADDR_SIZE-1:0] O_mem_addr,
  output logic [C_MEM_DATA_SIZE-1:0] O_mem_data,
  output logic                       O_mem_we,
  output logic [C_ECC_BITS-1:0]      O_ecc,
  output logic                       O_busy,
  output logic                       O_done
);

  localparam int K   = C_I_DATABITS;
  localparam int E   = C_ECC_BITS;
  localparam int W   = C_MEM_DATA_SIZE;
  localparam int AW  = C_MEM_ADDR_SIZE;
  localparam int LP_MEM_CYCLE = mem_cycle(E, W);
  localparam int PW  = W * LP_MEM_CYCLE;
  localparam int BCW = (K > 1) ? $clog2(K) : 1;
  localparam int WCW = $clog2(LP_MEM_CYCLE + 1);

  bch_state_t     state_q, state_d;
  logic           start_prev_q, start_prev_d;
  logic [K-1:0]   msg_q, msg_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [W-1:0]   data_q, data_d;
  logic           we_q, we_d;
  logic [E-1:0]   ecc_q, ecc_d;
  logic           done_q, done_d;
  logic           lfsr_clear, lfsr_shift;
  logic [E-1:0]   par, par_next;

  // Word idx of the zero-padded parity; word 0 holds the least-significant bits.
  function automatic logic [W-1:0] chunk(input logic [E-1:0] p, input int idx);
    logic [PW-1:0] pad;
    pad = PW'(p);
    pad = pad >> (W * idx);
    return pad[W-1:0];
  endfunction

  bch_lfsr_parity #(
    .C_ECC_BITS (E),
    .C_GEN_POLY (C_GEN_POLY)
  ) u_lfsr (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_clear    (lfsr_clear),
    .I_shift    (lfsr_shift),
    .I_bit      (msg_q[K-1]),
    .O_par      (par),
    .O_par_next (par_next)
  );

  // Sequencer: start detect, K encode cycles, LP_MEM_CYCLE writes, done pulse.
  always_comb begin
    state_d      = state_q;
    start_prev_d = I_start;
    msg_d        = msg_q;
    bcnt_d       = bcnt_q;
    wcnt_d       = wcnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    ecc_d        = ecc_q;
    done_d       = 1'b0;
    lfsr_clear   = 1'b0;
    lfsr_shift   = 1'b0;
    if (!I_en) begin
      state_d      = ST_IDLE;
      start_prev_d = 1'b0;
      msg_d        = '0;
      bcnt_d       = '0;
      wcnt_d       = '0;
      addr_d       = '0;
      data_d       = '0;
      we_d         = 1'b0;
      ecc_d        = '0;
      lfsr_clear   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_start && !start_prev_q) begin
            msg_d      = I_data;
            bcnt_d     = '0;
            lfsr_clear = 1'b1;
            state_d    = ST_ENC;
          end
        end
        ST_ENC: begin
          lfsr_shift = 1'b1;
          msg_d      = msg_q << 1;
          bcnt_d     = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(K - 1)) begin
            // The final division step lands on this edge, so the first
            // word is taken from the parity the LFSR is about to hold.
            state_d = ST_WRITE;
            we_d    = 1'b1;
            addr_d  = C_MEM_ST_ADDR;
            data_d  = chunk(par_next, 0);
            wcnt_d  = WCW'(1);
          end
        end
        ST_WRITE: begin
          if (wcnt_q == WCW'(LP_MEM_CYCLE)) begin
            we_d    = 1'b0;
            ecc_d   = par;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
            data_d = chunk(par, int'(wcnt_q));
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      msg_q        <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      ecc_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      msg_q        <= msg_d;
      bcnt_q       <= bcnt_d;
      wcnt_q       <= wcnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      ecc_q        <= ecc_d;
      done_q       <= done_d;
    end
  end

  assign O_mem_addr = addr_q;
  assign O_mem_data = data_q;
  assign O_mem_we   = we_q;
  assign O_ecc      = ecc_q;
  assign O_done     = done_q;
  assign O_busy     = (state_q == ST_ENC) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_bch_wrapper_encoder_mem.sv
// Bench for bch_wrapper_encoder_mem: a default instance (W=8, base 0) and a
// multi-word instance (W=2, base 3FF) checked every cycle against a
// polynomial-division model of when and what must appear on the outputs.
module tb_bch_wrapper_encoder_mem;

  localparam int K = 4;
  localparam int E = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en [2];
  logic       st [2];
  logic [3:0] dat [2];
  logic       we_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [9:0] addr_w [2];
  logic [2:0] ecc_w [2];
  logic [7:0] d0;
  logic [1:0] d1;
  logic [7:0] data_w [2];

  int nchk = 0;
  int nerr = 0;
  int dcnt [2];
  int wcnt [2];
  logic [7:0] mem [2][1024];

  int cW  [2] = '{8, 2};
  int cLP [2] = '{1, 2};
  int cST [2] = '{0, 1023};

  // model state
  bit act [2];
  int t [2];
  bit prv [2];
  int par_e [2];
  int ecc_e [2];

  always #5 clk = ~clk;

  bch_wrapper_encoder_mem dut0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en[0]), .I_start(st[0]), .I_data(dat[0]),
    .O_mem_addr(addr_w[0]), .O_mem_data(d0), .O_mem_we(we_w[0]),
    .O_ecc(ecc_w[0]), .O_busy(busy_w[0]), .O_done(done_w[0])
  );

  bch_wrapper_encoder_mem #(
    .C_MEM_DATA_SIZE(2), .C_MEM_ST_ADDR(10'h3FF)
  ) dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en[1]), .I_start(st[1]), .I_data(dat[1]),
    .O_mem_addr(addr_w[1]), .O_mem_data(d1), .O_mem_we(we_w[1]),
    .O_ecc(ecc_w[1]), .O_busy(busy_w[1]), .O_done(done_w[1])
  );

  always_comb begin
    data_w[0] = d0;
    data_w[1] = {6'b0, d1};
  end

  // Systematic parity = (msg * x^E) mod g(x), g = x^3 + x + 1.
  function automatic int bch_par(input int msg);
    int rem;
    int g;
    g   = (1 << E) | 3;
    rem = msg << E;
    for (int b = K + E - 1; b >= E; b--)
      if (rem[b]) rem = rem ^ (g << (b - E));
    return rem & ((1 << E) - 1);
  endfunction

  task automatic chk(input string nm, input longint a, input longint e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Reference model: counts edges since each accepted start.
  always @(posedge clk or negedge rst_n) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n || !en[j]) begin
        act[j] = 1'b0;
        prv[j] = 1'b0;
        ecc_e[j] = 0;
      end else begin
        if (act[j]) begin
          t[j]++;
          if (t[j] == K + cLP[j]) ecc_e[j] = par_e[j];
          if (t[j] > K + cLP[j]) act[j] = 1'b0;
        end else if (st[j] && !prv[j]) begin
          act[j] = 1'b1;
          t[j] = 0;
          par_e[j] = bch_par(int'(dat[j]));
        end
        prv[j] = st[j];
      end
    end
  end

  // Compare process: every output, every cycle, both instances.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      bit we_x, busy_x, done_x;
      int k;
      we_x   = act[j] && t[j] >= K && t[j] < K + cLP[j];
      busy_x = act[j] && t[j] < K + cLP[j];
      done_x = act[j] && t[j] == K + cLP[j];
      chk($sformatf("we%0d", j), longint'(we_w[j]), longint'(we_x));
      chk($sformatf("busy%0d", j), longint'(busy_w[j]), longint'(busy_x));
      chk($sformatf("done%0d", j), longint'(done_w[j]), longint'(done_x));
      chk($sformatf("ecc%0d", j), longint'(ecc_w[j]), longint'(ecc_e[j]));
      if (we_x && we_w[j]) begin
        k = t[j] - K;
        chk($sformatf("addr%0d", j), longint'(addr_w[j]), longint'((cST[j] + k) % 1024));
        chk($sformatf("data%0d", j), longint'(data_w[j]),
            longint'((par_e[j] >> (cW[j] * k)) & ((1 << cW[j]) - 1)));
      end
      if (we_w[j]) begin
        mem[j][addr_w[j]] = data_w[j];
        wcnt[j]++;
      end
      if (done_w[j]) dcnt[j]++;
    end
  end

  // One full operation: raise start, wait (bounded) for done, check latency.
  task automatic op(input int j, input logic [3:0] d, input int exp_edges);
    int n;
    bit got;
    @(negedge clk);
    dat[j] = d;
    st[j] = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      if (done_w[j]) got = 1'b1;
    end
    if (got) chk($sformatf("latency%0d", j), n - 1, exp_edges);
    else chk($sformatf("done_timeout%0d", j), 0, 1);
    st[j] = 1'b0;
  endtask

  initial begin
    int c, w, n;
    en[0] = 1'b1; en[1] = 1'b1;
    st[0] = 1'b0; st[1] = 1'b0;
    dat[0] = '0;  dat[1] = '0;
    dcnt[0] = 0; dcnt[1] = 0;
    wcnt[0] = 0; wcnt[1] = 0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rst_we%0d", j), longint'(we_w[j]), 0);
      chk($sformatf("rst_busy%0d", j), longint'(busy_w[j]), 0);
      chk($sformatf("rst_done%0d", j), longint'(done_w[j]), 0);
      chk($sformatf("rst_ecc%0d", j), longint'(ecc_w[j]), 0);
      chk($sformatf("rst_addr%0d", j), longint'(addr_w[j]), 0);
      chk($sformatf("rst_data%0d", j), longint'(data_w[j]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed single-word vectors with hand-computed parity.
    op(0, 4'b0001, 5);
    chk("ecc_0001", longint'(ecc_w[0]), 3'b011);
    chk("mem_0001", longint'(mem[0][0]), 8'h03);
    op(0, 4'b1000, 5);
    chk("ecc_1000", longint'(ecc_w[0]), 3'b101);
    chk("mem_1000", longint'(mem[0][0]), 8'h05);
    op(0, 4'b1111, 5);
    chk("mem_1111", longint'(mem[0][0]), 8'h07);
    c = dcnt[0]; w = wcnt[0];
    op(0, 4'b0000, 5);
    chk("mem_0000", longint'(mem[0][0]), 8'h00);
    chk("zero_writes", wcnt[0] - w, 1);
    chk("zero_dones", dcnt[0] - c, 1);

    // Multi-word layout with address wrap.
    op(1, 4'b1000, 6);
    chk("wrap_hi", longint'(mem[1][1023]), 2'b01);
    chk("wrap_lo", longint'(mem[1][0]), 2'b01);
    chk("ecc1_1000", longint'(ecc_w[1]), 3'b101);

    // Held start plus a second rising edge during ENC: one operation only.
    @(negedge clk);
    dat[0] = 4'b0001; c = dcnt[0];
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk); st[0] = 1'b1;
    repeat (15) @(negedge clk);
    chk("held_dones", dcnt[0] - c, 1);
    st[0] = 1'b0;
    op(0, 4'b1000, 5);
    chk("retrigger_ecc", longint'(ecc_w[0]), 3'b101);

    // Enable dropped during WRITE on the multi-word instance.
    @(negedge clk);
    dat[1] = 4'b1111; st[1] = 1'b1;
    n = 0;
    while (n < 20 && !we_w[1]) begin @(negedge clk); n++; end
    chk("en_reach_write", longint'(we_w[1]), 1);
    st[1] = 1'b0; en[1] = 1'b0; c = dcnt[1]; w = wcnt[1];
    @(negedge clk);
    chk("en_we", longint'(we_w[1]), 0);
    chk("en_busy", longint'(busy_w[1]), 0);
    chk("en_addr", longint'(addr_w[1]), 0);
    chk("en_data", longint'(data_w[1]), 0);
    chk("en_ecc", longint'(ecc_w[1]), 0);
    repeat (5) @(negedge clk);
    en[1] = 1'b1;
    chk("en_no_done", dcnt[1] - c, 0);
    chk("en_no_write", wcnt[1] - w, 1);
    chk("en_partial", longint'(mem[1][1023]), 2'b11);
    op(1, 4'b0110, 6);
    chk("en_after_lo", longint'(mem[1][0]), 2'b00);
    chk("en_after_hi", longint'(mem[1][1023]), 2'b01);

    // Asynchronous reset mid-ENC.
    @(negedge clk);
    dat[0] = 4'b1111; st[0] = 1'b1;
    repeat (2) @(negedge clk);
    c = dcnt[0];
    @(posedge clk);
    #2 rst_n = 1'b0; st[0] = 1'b0;
    #1;
    chk("arst_we", longint'(we_w[0]), 0);
    chk("arst_busy", longint'(busy_w[0]), 0);
    chk("arst_done", longint'(done_w[0]), 0);
    chk("arst_ecc", longint'(ecc_w[0]), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_done", dcnt[0] - c, 0);
    op(0, 4'b1111, 5);
    chk("arst_after_ecc", longint'(ecc_w[0]), 3'b111);

    // A few random messages on both layouts; the model checks every cycle.
    for (int i = 0; i < 6; i++) begin
      op(0, 4'($urandom_range(0, 15)), 5);
      op(1, 4'($urandom_range(0, 15)), 6);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
